// File: rtl/om_pkg.sv
// Shared definitions for the output-memory write buffer.
package om_pkg;

    localparam int OM_ADDR_W = 4;
    localparam int OM_DATA_W = 64;

    // One buffered output-memory write.
    typedef struct packed {
        logic [OM_ADDR_W-1:0] addr;
        logic [OM_DATA_W-1:0] data;
    } om_entry_t;

endpackage

// File: rtl/om_buf_mem.sv
// Entry storage for the write buffer: one write port, one async read port.
module om_buf_mem
    import om_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = OM_ADDR_W + OM_DATA_W
) (
    input  logic                     CLK,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store a pushed or coalesced entry.
    // NOTE: storage has no reset; Count gates every read, so stale contents are never observed.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/om_write_buffer.sv
// Output-memory write buffer: DEPTH-entry FIFO with stall handshake and
// optional coalescing of back-to-back writes to the newest entry's address.
module om_write_buffer
    import om_pkg::*;
#(
    parameter int ADDR_W   = OM_ADDR_W,
    parameter int DATA_W   = OM_DATA_W,
    parameter int DEPTH    = 4,
    parameter int COALESCE = 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [ADDR_W-1:0]          ODST_o,
    input  logic                       OMWrite_o,
    input  logic [DATA_W-1:0]          OMEM_Data_o,
    output logic                       OStall,
    output logic [ADDR_W-1:0]          ODST_om,
    output logic                       OMWrite_om,
    output logic [DATA_W-1:0]          OMEM_Data_om,
    input  logic                       OM_Ready,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] newest_addr_q;   // address of the most recently pushed entry
    logic [ENT_W-1:0]  head_entry;
    logic [PTR_W-1:0]  mem_wr_idx;
    logic              occupied;
    logic              full;
    logic              pop;
    logic              hit;
    logic              push;

    assign occupied = (Count != '0);
    assign full     = (Count == FULL_CNT);

    // Decide this cycle's pop, coalesce hit and push.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        pop  = 1'b0;
        hit  = 1'b0;
        push = 1'b0;
        pop  = occupied && OM_Ready;
        // A lone entry leaving this cycle cannot be merged into; the write becomes a push.
        hit  = (COALESCE != 0) && OMWrite_o && occupied && (ODST_o == newest_addr_q)
               && !((Count == ONE_CNT) && pop);
        push = OMWrite_o && !hit && !full;
    end

    assign OStall = full && !hit;

    // A hit rewrites the newest entry, which sits one slot behind wr_ptr.
    assign mem_wr_idx = hit ? (wr_ptr - PTR_W'(1)) : wr_ptr;

    om_buf_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_mem (
        .CLK     (CLK),
        .wr_en   (push || hit),
        .wr_idx  (mem_wr_idx),
        .wr_data ({ODST_o, OMEM_Data_o}),
        .rd_idx  (rd_ptr),
        .rd_data (head_entry)
    );

    // Advance pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            Count         <= '0;
            newest_addr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr        <= wr_ptr + PTR_W'(1);
                newest_addr_q <= ODST_o;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                Count <= Count + ONE_CNT;
            end else if (pop && !push) begin
                Count <= Count - ONE_CNT;
            end
        end
    end

    assign OMWrite_om   = occupied;
    assign ODST_om      = occupied ? head_entry[ENT_W-1:DATA_W] : '0;
    assign OMEM_Data_om = occupied ? head_entry[DATA_W-1:0]     : '0;

endmodule

// File: tb/tb_om_write_buffer.sv
// Directed testbench for om_write_buffer (coalescing and plain-FIFO instances).
module tb_om_write_buffer;
    import om_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  ODST_o = '0;
    logic        OMWrite_o = 1'b0;
    logic [63:0] OMEM_Data_o = '0;
    logic        OM_Ready = 1'b0;

    logic        OStall, OMWrite_om;
    logic [3:0]  ODST_om;
    logic [63:0] OMEM_Data_om;
    logic [2:0]  Count;

    logic        nc_OStall, nc_OMWrite_om;
    logic [3:0]  nc_ODST_om;
    logic [63:0] nc_OMEM_Data_om;
    logic [2:0]  nc_Count;

    int n_total = 0;
    int n_pass  = 0;

    always #5 CLK = ~CLK;

    om_write_buffer #(.ADDR_W(4), .DATA_W(64), .DEPTH(4), .COALESCE(1)) dut (
        .CLK(CLK), .RST(RST), .ODST_o(ODST_o), .OMWrite_o(OMWrite_o), .OMEM_Data_o(OMEM_Data_o),
        .OStall(OStall), .ODST_om(ODST_om), .OMWrite_om(OMWrite_om), .OMEM_Data_om(OMEM_Data_om),
        .OM_Ready(OM_Ready), .Count(Count)
    );

    om_write_buffer #(.ADDR_W(4), .DATA_W(64), .DEPTH(4), .COALESCE(0)) dut_nc (
        .CLK(CLK), .RST(RST), .ODST_o(ODST_o), .OMWrite_o(OMWrite_o), .OMEM_Data_o(OMEM_Data_o),
        .OStall(nc_OStall), .ODST_om(nc_ODST_om), .OMWrite_om(nc_OMWrite_om), .OMEM_Data_om(nc_OMEM_Data_om),
        .OM_Ready(OM_Ready), .Count(nc_Count)
    );

    // Advance one clock; outputs are then observed 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        OMWrite_o = 1'b0;
        OM_Ready  = 1'b0;
        RST       = 1'b1;
        tick();
        RST       = 1'b0;
        tick();
    endtask

    task automatic set_wr(input logic [3:0] a, input logic [63:0] d);
        ODST_o      = a;
        OMEM_Data_o = d;
        OMWrite_o   = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int a = 1; a <= 3; a++) begin
            set_wr(4'(a), 64'h50 + 64'(a));
            tick();
        end
        #2 RST = 1'b1;
        #1;
        n_total++;
        if (Count !== 3'd0) $display("FAIL reset_async_count: got %0d want 0", Count); else n_pass++;
        tick();
        OMWrite_o = 1'b0;
        RST = 1'b0;
        tick();
        n_total++;
        if (Count !== 3'd0) $display("FAIL reset_count: got %0d want 0", Count); else n_pass++;
        n_total++;
        if (OMWrite_om !== 1'b0) $display("FAIL reset_wr: got %0b want 0", OMWrite_om); else n_pass++;
        n_total++;
        if (ODST_om !== 4'd0) $display("FAIL reset_addr: got %0h want 0", ODST_om); else n_pass++;
        n_total++;
        if (OMEM_Data_om !== 64'd0) $display("FAIL reset_data: got %0h want 0", OMEM_Data_om); else n_pass++;
        n_total++;
        if (OStall !== 1'b0) $display("FAIL reset_stall: got %0b want 0", OStall); else n_pass++;
        n_total++;
        if (nc_Count !== 3'd0) $display("FAIL reset_nc_count: got %0d want 0", nc_Count); else n_pass++;
    endtask

    task automatic test_passthrough();
        do_reset();
        OM_Ready = 1'b1;
        set_wr(4'd3, 64'hA5);
        tick();
        OMWrite_o = 1'b0;
        #1;
        n_total++;
        if (OMWrite_om !== 1'b1) $display("FAIL pass_wr: got %0b want 1", OMWrite_om); else n_pass++;
        n_total++;
        if (ODST_om !== 4'd3) $display("FAIL pass_addr: got %0h want 3", ODST_om); else n_pass++;
        n_total++;
        if (OMEM_Data_om !== 64'hA5) $display("FAIL pass_data: got %0h want a5", OMEM_Data_om); else n_pass++;
        tick();
        n_total++;
        if (OMWrite_om !== 1'b0 || Count !== 3'd0 || OMEM_Data_om !== 64'd0)
            $display("FAIL pass_empty: got wr=%0b cnt=%0d data=%0h want 0/0/0", OMWrite_om, Count, OMEM_Data_om);
        else n_pass++;
    endtask

    task automatic test_fill_stall();
        logic [3:0] exp_addr [5];
        exp_addr = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
        do_reset();
        for (int a = 1; a <= 4; a++) begin
            set_wr(4'(a), 64'h100 + 64'(a));
            #1;
            n_total++;
            if (OStall !== 1'b0) $display("FAIL fill_nostall_%0d: got %0b want 0", a, OStall); else n_pass++;
            tick();
        end
        set_wr(4'd5, 64'h105);
        #1;
        n_total++;
        if (Count !== 3'd4 || OStall !== 1'b1) $display("FAIL fill_full: got cnt=%0d stall=%0b want 4/1", Count, OStall); else n_pass++;
        tick();
        n_total++;
        if (Count !== 3'd4 || ODST_om !== 4'd1) $display("FAIL fill_ignored: got cnt=%0d head=%0h want 4/1", Count, ODST_om); else n_pass++;
        OM_Ready = 1'b1;
        #1;
        n_total++;
        if (OStall !== 1'b1) $display("FAIL full_pop_stall: got %0b want 1", OStall); else n_pass++;
        n_total++;
        if (OMEM_Data_om !== 64'h101) $display("FAIL drain_data_1: got %0h want 101", OMEM_Data_om); else n_pass++;
        tick();
        n_total++;
        if (Count !== 3'd3 || OStall !== 1'b0) $display("FAIL after_pop: got cnt=%0d stall=%0b want 3/0", Count, OStall); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (ODST_om !== exp_addr[i]) $display("FAIL drain_addr_%0d: got %0h want %0h", i, ODST_om, exp_addr[i]); else n_pass++;
            tick();
            OMWrite_o = 1'b0;
        end
        n_total++;
        if (Count !== 3'd0) $display("FAIL drain_count: got %0d want 0", Count); else n_pass++;
    endtask

    task automatic test_coalesce();
        do_reset();
        set_wr(4'd7, 64'h11);
        tick();
        set_wr(4'd7, 64'h22);
        tick();
        OMWrite_o = 1'b0;
        #1;
        n_total++;
        if (Count !== 3'd1 || OMEM_Data_om !== 64'h22) $display("FAIL coal_merge: got cnt=%0d data=%0h want 1/22", Count, OMEM_Data_om); else n_pass++;
        n_total++;
        if (nc_Count !== 3'd2 || nc_OMEM_Data_om !== 64'h11) $display("FAIL nocoal_first: got cnt=%0d data=%0h want 2/11", nc_Count, nc_OMEM_Data_om); else n_pass++;
        OM_Ready = 1'b1;
        tick();
        n_total++;
        if (Count !== 3'd0) $display("FAIL coal_drain: got cnt=%0d want 0", Count); else n_pass++;
        n_total++;
        if (nc_Count !== 3'd1 || nc_OMEM_Data_om !== 64'h22) $display("FAIL nocoal_second: got cnt=%0d data=%0h want 1/22", nc_Count, nc_OMEM_Data_om); else n_pass++;
        tick();
        n_total++;
        if (nc_Count !== 3'd0) $display("FAIL nocoal_drain: got cnt=%0d want 0", nc_Count); else n_pass++;
    endtask

    task automatic test_coalesce_full();
        do_reset();
        for (int a = 1; a <= 4; a++) begin
            set_wr(4'(a), 64'h10 + 64'(a));
            tick();
        end
        set_wr(4'd4, 64'h99);
        #1;
        n_total++;
        if (OStall !== 1'b0) $display("FAIL full_hit_stall: got %0b want 0", OStall); else n_pass++;
        n_total++;
        if (nc_OStall !== 1'b1) $display("FAIL nocoal_full_stall: got %0b want 1", nc_OStall); else n_pass++;
        tick();
        OMWrite_o = 1'b0;
        OM_Ready  = 1'b1;
        n_total++;
        if (Count !== 3'd4) $display("FAIL full_hit_count: got %0d want 4", Count); else n_pass++;
        tick();
        tick();
        tick();
        n_total++;
        if (ODST_om !== 4'd4 || OMEM_Data_om !== 64'h99) $display("FAIL full_hit_data: got %0h/%0h want 4/99", ODST_om, OMEM_Data_om); else n_pass++;
        n_total++;
        if (nc_ODST_om !== 4'd4 || nc_OMEM_Data_om !== 64'h14) $display("FAIL nocoal_full_data: got %0h/%0h want 4/14", nc_ODST_om, nc_OMEM_Data_om); else n_pass++;
        tick();
    endtask

    task automatic test_wrap();
        om_entry_t q[$];
        om_entry_t e;
        int nxt = 0;
        bit pop_m, push_m;
        do_reset();
        for (int cyc = 0; cyc < 24; cyc++) begin
            set_wr(4'(nxt), 64'hD000 + 64'(nxt));
            OM_Ready = cyc[0];
            #1;
            n_total++;
            if (Count !== 3'(q.size())) $display("FAIL wrap_count_%0d: got %0d want %0d", cyc, Count, q.size()); else n_pass++;
            n_total++;
            if (OStall !== (q.size() == 4)) $display("FAIL wrap_stall_%0d: got %0b want %0b", cyc, OStall, q.size() == 4); else n_pass++;
            if (q.size() != 0) begin
                n_total++;
                if (ODST_om !== q[0].addr || OMEM_Data_om !== q[0].data)
                    $display("FAIL wrap_head_%0d: got %0h/%0h want %0h/%0h", cyc, ODST_om, OMEM_Data_om, q[0].addr, q[0].data);
                else n_pass++;
            end
            pop_m  = (q.size() != 0) && OM_Ready;
            push_m = (q.size() < 4);
            if (pop_m) void'(q.pop_front());
            if (push_m) begin
                e.addr = ODST_o;
                e.data = OMEM_Data_o;
                q.push_back(e);
                nxt++;
            end
            tick();
        end
        OMWrite_o = 1'b0;
        OM_Ready  = 1'b1;
        for (int i = 0; i < 8 && q.size() != 0; i++) begin
            #1;
            n_total++;
            if (ODST_om !== q[0].addr || OMEM_Data_om !== q[0].data)
                $display("FAIL wrap_drain_%0d: got %0h/%0h want %0h/%0h", i, ODST_om, OMEM_Data_om, q[0].addr, q[0].data);
            else n_pass++;
            void'(q.pop_front());
            tick();
        end
        n_total++;
        if (Count !== 3'd0 || OMWrite_om !== 1'b0) $display("FAIL wrap_empty: got cnt=%0d wr=%0b want 0/0", Count, OMWrite_om); else n_pass++;
    endtask

    task automatic test_hit_pop();
        do_reset();
        set_wr(4'd9, 64'h1);
        tick();
        set_wr(4'd9, 64'h2);
        OM_Ready = 1'b1;
        #1;
        n_total++;
        if (OMWrite_om !== 1'b1 || OMEM_Data_om !== 64'h1) $display("FAIL hitpop_first: got wr=%0b data=%0h want 1/1", OMWrite_om, OMEM_Data_om); else n_pass++;
        tick();
        OMWrite_o = 1'b0;
        n_total++;
        if (Count !== 3'd1 || OMEM_Data_om !== 64'h2) $display("FAIL hitpop_second: got cnt=%0d data=%0h want 1/2", Count, OMEM_Data_om); else n_pass++;
        tick();
        n_total++;
        if (Count !== 3'd0) $display("FAIL hitpop_empty: got %0d want 0", Count); else n_pass++;
        OM_Ready = 1'b0;
        set_wr(4'd1, 64'hA);
        tick();
        set_wr(4'd2, 64'hB);
        tick();
        set_wr(4'd2, 64'hC);
        OM_Ready = 1'b1;
        tick();
        OMWrite_o = 1'b0;
        n_total++;
        if (Count !== 3'd1 || ODST_om !== 4'd2 || OMEM_Data_om !== 64'hC)
            $display("FAIL hit2_pop: got cnt=%0d head=%0h/%0h want 1/2/c", Count, ODST_om, OMEM_Data_om);
        else n_pass++;
        tick();
        n_total++;
        if (Count !== 3'd0) $display("FAIL hit2_empty: got %0d want 0", Count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_fill_stall();
        test_coalesce();
        test_coalesce_full();
        test_wrap();
        test_hit_pop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
